pipeline_sequencer: RTL and testbench

- Sequences the 4 pipeline-register enables (IF/ID, ID/EXE, EXE/MEM, MEM/WR) and the PC enable for the 5-stage core.
- Sits beside the opcode decoder. It owns the enables; the decoder keeps mux/ALU/memory selects.
- Handles post-reset pipeline fill, load-use stalls, jump flush and data-memory wait freeze, with a wait timeout.

---
 rtl/pipeline_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Owns the PC enable and the four pipeline-register enables of the 5-stage
//   core. It handles post-reset fill, load-use stalls, jump flush and
//   data-memory wait freeze. A timeout forces the pipeline to resume if the
//   memory wait lasts too long.
//
// Parameters
//   LOAD_STALL_CYCLES  bubble cycles per load-use hazard (1..15)
//   MEM_TIMEOUT        max consecutive wait cycles before forced resume (1..255)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_opcode/id_rs/id_rt           instruction currently in ID
//   ex_rt, ex_mem_read              destination and lw flag of EXE instruction
//   mem_busy                        data memory not ready this cycle
//   pc_enable .. mem_wr_enable      register load enables (active high)
//   if_id_flush, id_exe_bubble      NOP injection into IF/ID, ID/EXE
//   mem_timeout                     sticky wait-timeout error, reset only
//   stall_count                     (STALL_COUNT_EN only) saturating count of
//                                   cycles outside FILL with pc_enable low
//
// Optional feature macro: STALL_COUNT_EN
module pipeline_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        mem_busy,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_exe_enable,
    output logic        exe_mem_enable,
    output logic        mem_wr_enable,
    output logic        if_id_flush,
    output logic        id_exe_bubble,
`ifdef STALL_COUNT_EN
    output logic [15:0] stall_count,
`endif
    output logic        mem_timeout
);

    typedef enum logic [1:0] {FILL, RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam bit MULTI_STALL = (LOAD_STALL_CYCLES > 1);

    state_t     state, state_d;
    logic [1:0] fill_cnt, fill_d;
    logic [3:0] stall_cnt, stall_d;
    logic [7:0] wait_cnt, wait_d;
    logic       to_q, to_d;
    logic       ign_busy, ign_d;   // one-cycle mem_busy mask after forced resume

    logic uses_rt, hazard, is_jump, run_eval, busy_eff;
    logic pc_c, ifid_c, idexe_c, exemem_c, memwr_c, flush_c, bubble_c;

    always_comb begin
        case (id_opcode)
            6'h20, 6'h24, 6'h25, 6'h27, 6'h22, 6'h00, 6'h02, 6'h33: uses_rt = 1'b1;
            default:                                                uses_rt = 1'b0;
        endcase
    end

    assign hazard   = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt));
    assign is_jump  = (id_opcode == 6'h03);
    assign busy_eff = mem_busy && !(ign_busy && state == RUN);

    always_comb begin
        pc_c = 1'b0; ifid_c = 1'b0; idexe_c = 1'b0; exemem_c = 1'b0; memwr_c = 1'b0;
        flush_c = 1'b0; bubble_c = 1'b0;
        state_d = state; fill_d = fill_cnt; stall_d = stall_cnt; wait_d = wait_cnt;
        to_d = to_q; ign_d = 1'b0; run_eval = 1'b0;

        unique case (state)
            FILL: begin
                pc_c     = 1'b1;
                ifid_c   = 1'b1;
                idexe_c  = (fill_cnt >= 2'd1);
                exemem_c = (fill_cnt >= 2'd2);
                memwr_c  = (fill_cnt == 2'd3);
                if (fill_cnt == 2'd3) state_d = RUN;
                else                  fill_d  = fill_cnt + 2'd1;
            end
            LOAD_STALL: begin
                if (mem_busy) begin
                    // remaining bubble cycles are dropped; the wait freezes everything
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                    stall_d = 4'd0;
                end else begin
                    idexe_c = 1'b1; exemem_c = 1'b1; memwr_c = 1'b1; bubble_c = 1'b1;
                    if (stall_cnt == 4'(LOAD_STALL_CYCLES - 1)) begin
                        state_d = RUN;
                        stall_d = 4'd0;
                    end else begin
                        stall_d = stall_cnt + 4'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                        to_d    = 1'b1;
                        ign_d   = 1'b1;
                        state_d = RUN;
                        wait_d  = 8'd0;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_d = wait_cnt + 8'd1;
                    end
                end else begin
                    // memory ready: this cycle already behaves as a RUN cycle,
                    // so the freeze lasts exactly as long as mem_busy is high
                    run_eval = 1'b1;
                end
            end
            RUN: run_eval = 1'b1;
        endcase

        if (run_eval) begin
            if (busy_eff) begin
                state_d = MEM_WAIT;
                wait_d  = 8'd1;
            end else if (hazard) begin
                // hold PC and IF/ID, push a NOP into ID/EXE; a jump in ID waits
                idexe_c = 1'b1; exemem_c = 1'b1; memwr_c = 1'b1; bubble_c = 1'b1;
                wait_d  = 8'd0;
                if (MULTI_STALL) begin
                    state_d = LOAD_STALL;
                    stall_d = 4'd1;
                end else begin
                    state_d = RUN;
                end
            end else begin
                pc_c = 1'b1; ifid_c = 1'b1; idexe_c = 1'b1; exemem_c = 1'b1; memwr_c = 1'b1;
                flush_c = is_jump;
                wait_d  = 8'd0;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= 2'd0;
            stall_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
            to_q      <= 1'b0;
            ign_busy  <= 1'b0;
        end else begin
            state     <= state_d;
            fill_cnt  <= fill_d;
            stall_cnt <= stall_d;
            wait_cnt  <= wait_d;
            to_q      <= to_d;
            ign_busy  <= ign_d;
        end
    end

`ifdef STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= 16'd0;
        else if (state != FILL && !pc_c && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

    // FILL at count 0 already enables PC/IF-ID, so reset must force outputs low
    assign pc_enable      = rst_n & pc_c;
    assign if_id_enable   = rst_n & ifid_c;
    assign id_exe_enable  = rst_n & idexe_c;
    assign exe_mem_enable = rst_n & exemem_c;
    assign mem_wr_enable  = rst_n & memwr_c;
    assign if_id_flush    = rst_n & flush_c;
    assign id_exe_bubble  = rst_n & bubble_c;
    assign mem_timeout    = to_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer. u0: LOAD_STALL_CYCLES=1, MEM_TIMEOUT=4.
// u1: LOAD_STALL_CYCLES=3, MEM_TIMEOUT=255. Both share inputs.
// Output vector bits: {pc, if_id, id_exe, exe_mem, mem_wr, flush, bubble, timeout}.
module tb_pipeline_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       ex_mem_read = 1'b0, mem_busy = 1'b0;

    logic pc0, ifid0, ie0, em0, mw0, fl0, bb0, to0;
    logic pc1, ifid1, ie1, em1, mw1, fl1, bb1, to1;
`ifdef STALL_COUNT_EN
    logic [15:0] sc0, sc1;
`endif
    logic [7:0] o0, o1;
    assign o0 = {pc0, ifid0, ie0, em0, mw0, fl0, bb0, to0};
    assign o1 = {pc1, ifid1, ie1, em1, mw1, fl1, bb1, to1};

    int npass = 0, ntot = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_busy(mem_busy),
        .pc_enable(pc0), .if_id_enable(ifid0), .id_exe_enable(ie0), .exe_mem_enable(em0),
        .mem_wr_enable(mw0), .if_id_flush(fl0), .id_exe_bubble(bb0),
`ifdef STALL_COUNT_EN
        .stall_count(sc0),
`endif
        .mem_timeout(to0));

    pipeline_sequencer #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(255)) u1 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_busy(mem_busy),
        .pc_enable(pc1), .if_id_enable(ifid1), .id_exe_enable(ie1), .exe_mem_enable(em1),
        .mem_wr_enable(mw1), .if_id_flush(fl1), .id_exe_bubble(bb1),
`ifdef STALL_COUNT_EN
        .stall_count(sc1),
`endif
        .mem_timeout(to1));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drv(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic mr, input logic busy);
        id_opcode = op; id_rs = rs; id_rt = rt; ex_rt = ert; ex_mem_read = mr; mem_busy = busy;
    endtask

    // new inputs at the falling edge, sample 1ns later
    task automatic cyc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic mr, input logic busy);
        @(negedge clk);
        drv(op, rs, rt, ert, mr, busy);
        #1;
    endtask

    initial begin
        // ---- reset and fill ----
        @(negedge clk); #1;
        chk("reset_u0", 16'(o0), 16'h00);
        chk("reset_u1", 16'(o1), 16'h00);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("fill0", 16'(o0), 16'(8'b1100_0000));
        cyc(0, 0, 0, 0, 0, 0); chk("fill1", 16'(o0), 16'(8'b1110_0000));
        cyc(0, 0, 0, 0, 0, 0); chk("fill2", 16'(o0), 16'(8'b1111_0000));
        cyc(0, 0, 0, 0, 0, 0); chk("fill3", 16'(o0), 16'(8'b1111_1000));
        cyc(0, 0, 0, 0, 0, 0); chk("run",   16'(o0), 16'(8'b1111_1000));

        // ---- load-use hazards (u0: single bubble) ----
        cyc(6'h08, 5, 0, 5, 1, 0); chk("rs_hazard",    16'(o0), 16'(8'b0011_1010));
        cyc(0, 0, 0, 0, 0, 0);     chk("after_hazard", 16'(o0), 16'(8'b1111_1000));
        cyc(6'h08, 0, 0, 0, 1, 0); chk("rt0_nostall",  16'(o0), 16'(8'b1111_1000));
        cyc(6'h00, 1, 7, 7, 1, 0); chk("rt_hazard",    16'(o0), 16'(8'b0011_1010));
        cyc(6'h23, 1, 7, 7, 1, 0); chk("rt_unused",    16'(o0), 16'(8'b1111_1000));

        // ---- jump flush ----
        cyc(6'h03, 0, 0, 0, 0, 0); chk("jump",         16'(o0), 16'(8'b1111_1100));
        cyc(0, 0, 0, 0, 0, 0);     chk("jump_once",    16'(o0), 16'(8'b1111_1000));
        cyc(6'h03, 5, 0, 5, 1, 0); chk("jump_hazard",  16'(o0), 16'(8'b0011_1010));
        cyc(6'h03, 0, 0, 0, 0, 0); chk("jump_release", 16'(o0), 16'(8'b1111_1100));

        // ---- 3-cycle memory wait ----
        cyc(0, 0, 0, 0, 0, 1); chk("busy1",   16'(o0), 16'h00);
        cyc(0, 0, 0, 0, 0, 1); chk("busy2",   16'(o0), 16'h00);
        cyc(0, 0, 0, 0, 0, 1); chk("busy3",   16'(o0), 16'h00);
        cyc(0, 0, 0, 0, 0, 0); chk("resume",  16'(o0), 16'(8'b1111_1000));
        cyc(0, 0, 0, 0, 0, 0); chk("resume2", 16'(o0), 16'(8'b1111_1000));

        // ---- timeout (u0 MEM_TIMEOUT=4) ----
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 1); chk("to_wait", 16'(o0), 16'h00);
        end
        cyc(0, 0, 0, 0, 0, 1); chk("forced_resume", 16'(o0), 16'(8'b1111_1001));
        cyc(0, 0, 0, 0, 0, 1); chk("to_rewait",     16'(o0), 16'(8'b0000_0001));
        cyc(0, 0, 0, 0, 0, 0); chk("to_sticky",     16'(o0), 16'(8'b1111_1001));
        @(negedge clk); rst_n = 1'b0; #1;
        chk("to_cleared", 16'(o0), 16'h00);

        // ---- refill with busy/hazard ignored ----
        @(negedge clk); rst_n = 1'b1; drv(6'h08, 5, 0, 5, 1, 1); #1;
        chk("fill_ign0_u0", 16'(o0), 16'(8'b1100_0000));
        chk("fill_ign0_u1", 16'(o1), 16'(8'b1100_0000));
        cyc(6'h08, 5, 0, 5, 1, 1); chk("fill_ign1", 16'(o0), 16'(8'b1110_0000));
        cyc(6'h08, 5, 0, 5, 1, 1); chk("fill_ign2", 16'(o1), 16'(8'b1111_0000));
        cyc(6'h08, 5, 0, 5, 1, 1); chk("fill_ign3", 16'(o0), 16'(8'b1111_1000));
        cyc(0, 0, 0, 0, 0, 0);     chk("run_u1",    16'(o1), 16'(8'b1111_1000));
`ifdef STALL_COUNT_EN
        chk("sc_zero", sc0, 16'd0);
`endif

        // ---- 1 hazard + 3 busy ----
        cyc(6'h08, 5, 0, 5, 1, 0); chk("c1_u0", 16'(o0), 16'(8'b0011_1010));
        chk("c1_u1", 16'(o1), 16'(8'b0011_1010));
        cyc(0, 0, 0, 0, 0, 1);     chk("c2_u1_busy_prio", 16'(o1), 16'h00);
        cyc(0, 0, 0, 0, 0, 1);     chk("c3", 16'(o0), 16'h00);
        cyc(0, 0, 0, 0, 0, 1);     chk("c4", 16'(o1), 16'h00);
        cyc(0, 0, 0, 0, 0, 0);     chk("c5_u1", 16'(o1), 16'(8'b1111_1000));
`ifdef STALL_COUNT_EN
        chk("sc4_u0", sc0, 16'd4);
        chk("sc4_u1", sc1, 16'd4);
`endif

        // ---- u1 three-cycle load stall ----
        cyc(6'h08, 5, 0, 5, 1, 0); chk("ls0_u1", 16'(o1), 16'(8'b0011_1010));
        cyc(0, 0, 0, 0, 0, 0);     chk("ls1_u1", 16'(o1), 16'(8'b0011_1010));
        chk("ls1_u0", 16'(o0), 16'(8'b1111_1000));
        cyc(0, 0, 0, 0, 0, 0);     chk("ls2_u1", 16'(o1), 16'(8'b0011_1010));
        cyc(0, 0, 0, 0, 0, 0);     chk("ls_end_u1", 16'(o1), 16'(8'b1111_1000));

        // ---- reset mid-wait ----
        cyc(0, 0, 0, 0, 0, 1);     chk("w1_u0", 16'(o0), 16'h00);
        cyc(0, 0, 0, 0, 0, 1);     chk("w2_u1", 16'(o1), 16'h00);
`ifdef STALL_COUNT_EN
        chk("sc_pre_u0", sc0, 16'd6);
        chk("sc_pre_u1", sc1, 16'd8);
`endif
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_wait_u0", 16'(o0), 16'h00);
        chk("rst_wait_u1", 16'(o1), 16'h00);
`ifdef STALL_COUNT_EN
        chk("sc_rst_u0", sc0, 16'd0);
        chk("sc_rst_u1", sc1, 16'd0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
